// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the asynchronous serial receiver.
//   - FSM state encoding (3 bits): IDLE / START / DATA / STOP / BREAK
//   - LINE_IDLE: level of an idle serial line
//   - cnt_width(): width of a counter that must hold 0..n-1
package serial_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  localparam logic LINE_IDLE = 1'b1;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    if (n > 32'sd1) begin
      w = $clog2(n);
    end else begin
      w = 32'sd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk  in  sampling clock
//   rst  in  asynchronous reset, active-low; both flops load RESET_VAL
//   d    in  asynchronous input
//   q    out synchronised output (two clk edges of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_r <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// serial_rx: asynchronous serial receiver, partner of SerialTx.
// Bit period P = 2**TimerWidth clocks. Start bit is qualified at its middle,
// data bits and the stop bit are sampled at mid-period from there.
// Ports:
//   clk        in  sole clock, rising edge
//   rst        in  asynchronous reset, active-low
//   rx         in  serial line, idle high, asynchronous to clk
//   ack        in  consumer has taken Q; clears valid and overrun
//   Q          out received word; first data bit on the line lands in Q[Width-1]
//   valid      out Q holds an unconsumed word
//   busy       out receiver is not in IDLE
//   frame_err  out one-clock pulse when the stop bit is sampled low
//   overrun    out sticky: a good frame completed while valid=1 and was dropped
module serial_rx
  import serial_pkg::*;
#(
  parameter int Width      = 8,
  parameter int TimerWidth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic             ack,
  output logic [0:Width-1] Q,
  output logic             valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int BW = cnt_width(Width);

  localparam logic [TimerWidth-1:0] TIMER_ZERO = {TimerWidth{1'b0}};
  localparam logic [TimerWidth-1:0] TIMER_ONE  = {{(TimerWidth-1){1'b0}}, 1'b1};
  // P/2-1 and P-1 for a power-of-two period
  localparam logic [TimerWidth-1:0] HALF_LAST  = {1'b0, {(TimerWidth-1){1'b1}}};
  localparam logic [TimerWidth-1:0] FULL_LAST  = {TimerWidth{1'b1}};

  localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE  = BW'(32'd1);
  localparam logic [BW-1:0] BIT_LAST = BW'(Width - 32'sd1);

  logic                  rx_s;
  logic [2:0]            state_r;
  logic [2:0]            state_nxt_s;
  logic [TimerWidth-1:0] timer_r;
  logic [TimerWidth-1:0] timer_nxt_s;
  logic [BW-1:0]         bitcnt_r;
  logic [BW-1:0]         bitcnt_nxt_s;
  logic [Width-1:0]      shift_r;
  logic                  shift_en_s;
  logic                  good_done_s;
  logic                  bad_stop_s;
  logic                  ack_take_s;

  sync_2ff #(
    .RESET_VAL (LINE_IDLE)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Consumer acknowledgement only counts while a word is pending.
  assign ack_take_s = ack & valid;

  // Next-state, timer and bit-counter logic of the receive FSM.
  always_comb begin
    state_nxt_s  = state_r;
    timer_nxt_s  = timer_r;
    bitcnt_nxt_s = bitcnt_r;
    shift_en_s   = 1'b0;
    good_done_s  = 1'b0;
    bad_stop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_s != LINE_IDLE) begin
          state_nxt_s = ST_START;
          timer_nxt_s = TIMER_ZERO;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (timer_r == HALF_LAST) begin
          timer_nxt_s = TIMER_ZERO;
          if (rx_s == LINE_IDLE) begin
            // line went back high before mid-bit: a glitch, not a start bit
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s  = ST_DATA;
            bitcnt_nxt_s = BIT_ZERO;
          end
        end else begin
          timer_nxt_s = timer_r + TIMER_ONE;
        end
      end
      ST_DATA: begin
        if (timer_r == FULL_LAST) begin
          timer_nxt_s = TIMER_ZERO;
          shift_en_s  = 1'b1;
          if (bitcnt_r == BIT_LAST) begin
            state_nxt_s  = ST_STOP;
            bitcnt_nxt_s = BIT_ZERO;
          end else begin
            bitcnt_nxt_s = bitcnt_r + BIT_ONE;
          end
        end else begin
          timer_nxt_s = timer_r + TIMER_ONE;
        end
      end
      ST_STOP: begin
        if (timer_r == FULL_LAST) begin
          timer_nxt_s = TIMER_ZERO;
          if (rx_s == LINE_IDLE) begin
            good_done_s = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            // low stop bit: wait for the line to recover so a held-low
            // line is not mistaken for a stream of start bits
            bad_stop_s  = 1'b1;
            state_nxt_s = ST_BREAK;
          end
        end else begin
          timer_nxt_s = timer_r + TIMER_ONE;
        end
      end
      ST_BREAK: begin
        if (rx_s == LINE_IDLE) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        timer_nxt_s  = TIMER_ZERO;
        bitcnt_nxt_s = BIT_ZERO;
      end
    endcase
  end

  // FSM state, timer, bit counter and busy flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      timer_r  <= TIMER_ZERO;
      bitcnt_r <= BIT_ZERO;
      busy     <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      timer_r  <= timer_nxt_s;
      bitcnt_r <= bitcnt_nxt_s;
      busy     <= (state_nxt_s != ST_IDLE);
    end
  end

  // Data shift register; bits enter at the top so the first bit ends at shift_r[0].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r <= {Width{1'b0}};
    end else if (shift_en_s) begin
      shift_r <= {rx_s, shift_r[Width-1:1]};
    end else begin
      shift_r <= shift_r;
    end
  end

  // Output word, valid/ack handshake, overrun and framing-error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Q         <= {Width{1'b0}};
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop_s;
      if (good_done_s) begin
        if (!valid || ack_take_s) begin
          // slot is free, or is being freed on this very edge
          Q     <= shift_r;
          valid <= 1'b1;
          if (ack_take_s) begin
            overrun <= 1'b0;
          end else begin
            overrun <= overrun;
          end
        end else begin
          overrun <= 1'b1;
        end
      end else if (ack_take_s) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end else begin
        valid   <= valid;
        overrun <= overrun;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: directed self-checking bench for serial_rx
// (Width=8, TimerWidth=4, so P=16 clocks per bit).
module tb_serial_rx;

  localparam int W  = 8;
  localparam int TW = 4;
  localparam int P  = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx;
  logic         ack;
  logic [0:W-1] Q;
  logic         valid;
  logic         busy;
  logic         frame_err;
  logic         overrun;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int fe_cnt = 0;
  logic valid_q = 1'b0;
  int c0;
  int fe0;

  serial_rx #(
    .Width      (W),
    .TimerWidth (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .ack       (ack),
    .Q         (Q),
    .valid     (valid),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Count rising edges so latencies can be measured.
  always @(posedge clk) cyc <= cyc + 1;

  // Record the last rise of valid and count cycles with frame_err high.
  always @(negedge clk) begin
    if (valid && !valid_q) rise_cyc <= cyc;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    valid_q <= valid;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmit one frame LSB first, starting at the current negedge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    repeat (P) @(negedge clk);
    for (int i = 0; i < W; i++) begin
      rx = d[i];
      repeat (P) @(negedge clk);
    end
    rx = stop_bit;
    repeat (P) @(negedge clk);
    if (stop_bit) rx = 1'b1;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    ack = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_q", Q, 32'h0);
    check_val("rst_valid", valid, 32'h0);
    check_val("rst_busy", busy, 32'h0);
    check_val("rst_ferr", frame_err, 32'h0);
    check_val("rst_ovr", overrun, 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Clean frame 3C with latency measurement
    c0  = cyc;
    fe0 = fe_cnt;
    fork
      send_frame(8'h3C, 1'b1);
      begin
        repeat (40) @(negedge clk);
        check_val("busy_mid", busy, 32'h1);
      end
    join
    repeat (4) @(negedge clk);
    check_val("f1_q", Q, 32'h3C);
    check_val("f1_valid", valid, 32'h1);
    check_val("f1_latency", rise_cyc - (c0 + 1), 32'd154);
    check_val("f1_ferr", fe_cnt - fe0, 32'h0);
    check_val("f1_ovr", overrun, 32'h0);
    ack_pulse();
    check_val("f1_ack_valid", valid, 32'h0);

    // Glitch: 5 clocks low
    c0  = cyc;
    fe0 = fe_cnt;
    rx  = 1'b0;
    repeat (3) @(negedge clk);
    check_val("gl_busy_start", busy, 32'h1);
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check_val("gl_busy_idle", busy, 32'h0);
    repeat (30) @(negedge clk);
    check_val("gl_valid", valid, 32'h0);
    check_val("gl_ovr", overrun, 32'h0);
    check_val("gl_ferr", fe_cnt - fe0, 32'h0);

    // Low stop bit, then line held low
    fe0 = fe_cnt;
    send_frame(8'hFF, 1'b0);
    repeat (100) @(negedge clk);
    check_val("brk_ferr_once", fe_cnt - fe0, 32'h1);
    check_val("brk_valid", valid, 32'h0);
    check_val("brk_busy_hold", busy, 32'h1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check_val("brk_busy_rel", busy, 32'h0);
    repeat (200) @(negedge clk);
    check_val("brk_no_frame", valid, 32'h0);
    check_val("brk_ferr_end", fe_cnt - fe0, 32'h1);

    // Two back-to-back frames without ack
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    check_val("ovr_q", Q, 32'h11);
    check_val("ovr_valid", valid, 32'h1);
    check_val("ovr_flag", overrun, 32'h1);
    ack_pulse();
    check_val("ovr_ack_valid", valid, 32'h0);
    check_val("ovr_ack_flag", overrun, 32'h0);

    // ack on the completion edge of a second frame
    send_frame(8'h11, 1'b1);
    repeat (4) @(negedge clk);
    check_val("sa_first_valid", valid, 32'h1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (154) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check_val("sa_q", Q, 32'h22);
    check_val("sa_valid", valid, 32'h1);
    check_val("sa_ovr", overrun, 32'h0);

    // Reset in the middle of data bit 4 (valid still set from above)
    rx = 1'b0;
    repeat (P) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (P) @(negedge clk);
    end
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check_val("mr_busy_before", busy, 32'h1);
    #2 rst = 1'b0;
    #1;
    check_val("mr_q", Q, 32'h0);
    check_val("mr_valid", valid, 32'h0);
    check_val("mr_busy", busy, 32'h0);
    check_val("mr_ovr", overrun, 32'h0);
    check_val("mr_ferr", frame_err, 32'h0);
    @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check_val("mr_idle", busy, 32'h0);
    fe0 = fe_cnt;
    send_frame(8'hA7, 1'b1);
    repeat (4) @(negedge clk);
    check_val("mr_a7_q", Q, 32'hA7);
    check_val("mr_a7_valid", valid, 32'h1);
    check_val("mr_a7_ovr", overrun, 32'h0);
    check_val("mr_a7_ferr", fe_cnt - fe0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
